// File: rtl/cachewbbuf_pkg.sv
// Shared types and constants for the victim writeback buffer.
package cachewbbuf_pkg;
    localparam int LINELEN_DEF = 512;
    localparam int BEATLEN_DEF = 64;
    localparam int NBEATS      = LINELEN_DEF / BEATLEN_DEF;
    localparam int BEATIDXLEN  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {IDLE, BURST} wbstatetype;

    // Beat index width, kept at least one bit for single-beat lines.
    function automatic int beatIdxLen(int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction
endpackage

// File: rtl/cachewbbuf_beatsel.sv
// Beat mux and byte-address generator for the line currently being drained.
module cachewbbeatsel import cachewbbuf_pkg::*; #(
    parameter int LINELEN   = LINELEN_DEF,
    parameter int BEATLEN   = BEATLEN_DEF,
    parameter int PA_BITS   = 56,
    parameter int OFFSETLEN = 6,
    parameter int NB        = LINELEN / BEATLEN,
    parameter int BI        = beatIdxLen(NB)
) (
    input  logic                         en,
    input  logic [LINELEN-1:0]           line,
    input  logic [PA_BITS-OFFSETLEN-1:0] lineAdr,
    input  logic [BI-1:0]                beat,
    output logic [PA_BITS-1:0]           adr,
    output logic [BEATLEN-1:0]           data,
    output logic                         last
);
    // Outputs forced to zero when idle so the bus sees clean values.
    always_comb begin
        data = '0;
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (beat == BI'(i)) data = line[i*BEATLEN +: BEATLEN];
            end
        end
    end

    assign adr  = en ? ({lineAdr, {OFFSETLEN{1'b0}}} + PA_BITS'(beat) * PA_BITS'(BEATLEN/8)) : '0;
    assign last = en && (beat == BI'(NB-1));
endmodule

// File: rtl/cachewbbuf.sv
// Two-entry victim writeback buffer: accepts whole dirty lines, drains them as bus bursts.
module cachewbbuf import cachewbbuf_pkg::*; #(
    parameter int LINELEN   = LINELEN_DEF,
    parameter int BEATLEN   = BEATLEN_DEF,
    parameter int PA_BITS   = 56,
    parameter int OFFSETLEN = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EvictValid,
    output logic               EvictReady,
    input  logic [PA_BITS-1:0] EvictAdr,
    input  logic [LINELEN-1:0] EvictLine,
    output logic               BusReq,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [BEATLEN-1:0] BusData,
    output logic               BusLast,
    input  logic               BusAck,
    input  logic [PA_BITS-1:0] ProbeAdr,
    output logic               ProbeHit,
    output logic               Empty
);
    localparam int NB = LINELEN / BEATLEN;
    localparam int BI = beatIdxLen(NB);
    localparam int LA = PA_BITS - OFFSETLEN;

    wbstatetype              state, nextState;
    logic [1:0]              entVld;
    logic [1:0][LA-1:0]      entAdr;
    logic [1:0][LINELEN-1:0] entLine;
    logic                    wrPtr, rdPtr;
    logic [1:0]              count;
    logic [BI-1:0]           beat;
    logic                    enq, ack, lastAck;
    logic                    unusedOffsetBits;

    assign unusedOffsetBits = ^{EvictAdr[OFFSETLEN-1:0], ProbeAdr[OFFSETLEN-1:0]};

    // Ready looks only at registered count; a same-cycle dequeue does not help.
    assign EvictReady = (count < 2'd2);
    assign enq        = EvictValid & EvictReady;
    assign ack        = (state == BURST) & BusAck;
    assign lastAck    = ack & (beat == BI'(NB-1));
    assign Empty      = (count == 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Stay in BURST across line boundaries when the other slot holds or is receiving a line.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (count != 2'd0) nextState = BURST;
            BURST:   if (lastAck && !(entVld[~rdPtr] || enq)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        BusReq = (state == BURST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entVld  <= '0;
            entAdr  <= '0;
            entLine <= '0;
            wrPtr   <= 1'b0;
            rdPtr   <= 1'b0;
            count   <= '0;
            beat    <= '0;
        end else begin
            if (enq) begin
                entVld[wrPtr]  <= 1'b1;
                entAdr[wrPtr]  <= EvictAdr[PA_BITS-1:OFFSETLEN];
                entLine[wrPtr] <= EvictLine;
                wrPtr          <= ~wrPtr;
            end
            if (lastAck) begin
                entVld[rdPtr] <= 1'b0;
                rdPtr         <= ~rdPtr;
            end
            count <= count + 2'(enq) - 2'(lastAck);
            if (lastAck)  beat <= '0;
            else if (ack) beat <= beat + BI'(1);
        end
    end

    always_comb begin
        ProbeHit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (entVld[i] && entAdr[i] == ProbeAdr[PA_BITS-1:OFFSETLEN]) ProbeHit = 1'b1;
        end
    end

    cachewbbeatsel #(
        .LINELEN(LINELEN), .BEATLEN(BEATLEN), .PA_BITS(PA_BITS),
        .OFFSETLEN(OFFSETLEN), .NB(NB), .BI(BI)
    ) beatSel (
        .en     (BusReq),
        .line   (entLine[rdPtr]),
        .lineAdr(entAdr[rdPtr]),
        .beat   (beat),
        .adr    (BusAdr),
        .data   (BusData),
        .last   (BusLast)
    );
endmodule

// File: tb/tb_cachewbbuf.sv
// Bench for cachewbbuf: queue-based reference model, per-scenario tasks.
module tb_cachewbbuf;
    import cachewbbuf_pkg::*;
    localparam int PA = 56;
    localparam int LL = 512;
    localparam int BL = 64;
    localparam int NB = NBEATS;

    logic          clk = 0, reset = 1;
    logic          EvictValid = 0, EvictReady;
    logic [PA-1:0] EvictAdr = '0;
    logic [LL-1:0] EvictLine = '0;
    logic          BusReq, BusLast, BusAck = 0;
    logic [PA-1:0] BusAdr;
    logic [BL-1:0] BusData;
    logic [PA-1:0] ProbeAdr = '0;
    logic          ProbeHit, Empty;

    cachewbbuf dut (
        .clk(clk), .reset(reset), .EvictValid(EvictValid), .EvictReady(EvictReady),
        .EvictAdr(EvictAdr), .EvictLine(EvictLine), .BusReq(BusReq), .BusAdr(BusAdr),
        .BusData(BusData), .BusLast(BusLast), .BusAck(BusAck), .ProbeAdr(ProbeAdr),
        .ProbeHit(ProbeHit), .Empty(Empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO of pending lines, beats acked on the head, request flag.
    typedef struct { logic [PA-1:0] adr; logic [LL-1:0] line; } ent_t;
    ent_t pend[$];
    int   mBeat = 0;
    bit   mReq  = 0;

    logic [124:0] act;
    assign act = {BusReq, BusLast, BusAdr, BusData, ProbeHit, Empty, EvictReady};

    function automatic logic [124:0] expVec();
        logic [PA-1:0] a; logic [BL-1:0] d; logic l, hit;
        a = '0; d = '0; l = 0; hit = 0;
        if (mReq) begin
            a = {pend[0].adr[PA-1:6], 6'b0} + PA'(mBeat * 8);
            d = pend[0].line[mBeat*BL +: BL];
            l = (mBeat == NB-1);
        end
        foreach (pend[i]) if (pend[i].adr[PA-1:6] == ProbeAdr[PA-1:6]) hit = 1;
        return {mReq, l, a, d, hit, pend.size() == 0, pend.size() < 2};
    endfunction

    function automatic logic [LL-1:0] rndLine();
        logic [LL-1:0] l;
        for (int i = 0; i < LL/32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic tick();
        int pre; bit enq, last;
        @(posedge clk);
        if (reset) begin
            pend.delete(); mBeat = 0; mReq = 0;
        end else begin
            pre = pend.size(); enq = EvictValid && pre < 2; last = 0;
            if (mReq && BusAck) begin
                if (mBeat == NB-1) begin last = 1; pend.delete(0); mBeat = 0; end
                else mBeat++;
            end
            if (enq) pend.push_back('{EvictAdr, EvictLine});
            mReq = mReq ? (!last || pend.size() > 0) : (pre > 0);
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (act !== 125'd3) begin errors++; $display("FAIL reset_outputs: got %h want %h", act, 125'd3); end
        checks++;
        if (act !== expVec()) begin errors++; $display("FAIL reset_model: got %h want %h", act, expVec()); end
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_single();
        logic [LL-1:0] l; int beats = 0;
        for (int k = 0; k < NB; k++) l[k*BL +: BL] = 64'h1111_1111_1111_1111 * 64'(k);
        EvictValid = 1; EvictAdr = 56'h8000_0040; EvictLine = l; BusAck = 1; ProbeAdr = '0;
        #1;
        checks++;
        if (act !== expVec()) begin errors++; $display("FAIL single_c0: got %h want %h", act, expVec()); end
        tick();
        EvictValid = 0;
        for (int c = 0; c < 11; c++) begin
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL single_c%0d: got %h want %h", c+1, act, expVec()); end
            if (BusReq && BusAck) begin
                checks++;
                if ({BusAdr, BusData, BusLast} !== {56'h8000_0040 + PA'(beats*8), 64'h1111_1111_1111_1111 * 64'(beats), 1'(beats == NB-1)}) begin
                    errors++; $display("FAIL single_beat%0d: got %h %h %b", beats, BusAdr, BusData, BusLast);
                end
                beats++;
            end
            tick();
        end
        checks++;
        if (beats !== NB || Empty !== 1'b1) begin errors++; $display("FAIL single_count: got beats=%0d empty=%b want %0d 1", beats, Empty, NB); end
    endtask

    task automatic test_stall();
        int acc = 0; bit hold = 0; logic [PA+BL-1:0] prevBus = '0;
        EvictValid = 1; EvictAdr = {$urandom, $urandom}; EvictLine = rndLine(); BusAck = 0;
        tick();
        EvictValid = 0;
        for (int c = 0; c < 200 && (pend.size() > 0 || mReq); c++) begin
            BusAck = 1'($urandom % 2);
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL stall_c%0d: got %h want %h", c, act, expVec()); end
            if (hold) begin
                checks++;
                if ({BusReq, BusAdr, BusData} !== {1'b1, prevBus}) begin
                    errors++; $display("FAIL stall_hold_c%0d: got %h want %h", c, {BusAdr, BusData}, prevBus);
                end
            end
            hold = BusReq && !BusAck; prevBus = {BusAdr, BusData};
            if (BusReq && BusAck) acc++;
            tick();
        end
        checks++;
        if (acc !== NB || pend.size() != 0) begin errors++; $display("FAIL stall_beats: got %0d want %0d", acc, NB); end
    endtask

    task automatic test_back_to_back();
        int reqCyc = 0;
        BusAck = 1;
        for (int n = 0; n < 3; n++) begin
            EvictValid = 1; EvictAdr = {$urandom, $urandom}; EvictLine = rndLine();
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL b2b_fill%0d: got %h want %h", n, act, expVec()); end
            if (n == 2) begin
                checks++;
                if (EvictReady !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", EvictReady); end
            end
            if (BusReq) reqCyc++;
            tick();
        end
        EvictValid = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL b2b_c%0d: got %h want %h", c, act, expVec()); end
            if (BusReq) reqCyc++;
            tick();
        end
        checks++;
        if (reqCyc !== 2*NB) begin errors++; $display("FAIL b2b_reqcycles: got %0d want %0d", reqCyc, 2*NB); end
    endtask

    task automatic test_probe();
        bit prevLast = 0;
        EvictValid = 1; EvictAdr = 56'h8000_0040; EvictLine = rndLine(); ProbeAdr = 56'h8000_0040; BusAck = 0;
        #1;
        checks++;
        if (ProbeHit !== 1'b0) begin errors++; $display("FAIL probe_enq_same_cycle: got %b want 0", ProbeHit); end
        tick();
        EvictValid = 0; ProbeAdr = 56'h8000_007C;
        #1;
        checks++;
        if (ProbeHit !== 1'b1) begin errors++; $display("FAIL probe_hit_7c: got %b want 1", ProbeHit); end
        ProbeAdr = 56'h8000_0080;
        #1;
        checks++;
        if (ProbeHit !== 1'b0) begin errors++; $display("FAIL probe_miss_80: got %b want 0", ProbeHit); end
        ProbeAdr = 56'h8000_0040; BusAck = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL probe_c%0d: got %h want %h", c, act, expVec()); end
            if (prevLast) begin
                checks++;
                if (ProbeHit !== 1'b0) begin errors++; $display("FAIL probe_after_last: got %b want 0", ProbeHit); end
            end
            if (BusLast && BusAck) begin
                checks++;
                if (ProbeHit !== 1'b1) begin errors++; $display("FAIL probe_at_last: got %b want 1", ProbeHit); end
            end
            prevLast = BusLast && BusAck;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        bit sentC = 0, sentD = 0; int acc = 0;
        BusAck = 0;
        for (int n = 0; n < 2; n++) begin
            EvictValid = 1; EvictAdr = {$urandom, $urandom}; EvictLine = rndLine();
            tick();
        end
        EvictValid = 0; BusAck = 1;
        for (int c = 0; c < 60 && (pend.size() > 0 || mReq || !sentD); c++) begin
            EvictValid = 0;
            if (!sentC && pend.size() < 2) begin
                EvictValid = 1; EvictAdr = {$urandom, $urandom}; EvictLine = rndLine(); sentC = 1;
            end else if (sentC && !sentD && mReq && mBeat == NB-1 && pend.size() == 1) begin
                EvictValid = 1; EvictAdr = {$urandom, $urandom}; EvictLine = rndLine(); sentD = 1;
            end
            ProbeAdr = EvictAdr;
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL simul_c%0d: got %h want %h", c, act, expVec()); end
            if (BusReq && BusAck) acc++;
            tick();
        end
        EvictValid = 0;
        checks++;
        if (acc !== 4*NB || !sentD) begin errors++; $display("FAIL simul_beats: got %0d want %0d", acc, 4*NB); end
    endtask

    task automatic test_reset_midburst();
        int acc = 0; logic [PA-1:0] a;
        BusAck = 1; EvictValid = 1; a = {$urandom, $urandom}; EvictAdr = a; EvictLine = rndLine(); ProbeAdr = a;
        tick();
        EvictValid = 0;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL rstmid_c%0d: got %h want %h", c, act, expVec()); end
            if (BusReq && BusAck) acc++;
            tick();
        end
        reset = 1;
        pend.delete(); mBeat = 0; mReq = 0;
        #1;
        checks++;
        if (act !== 125'd3) begin errors++; $display("FAIL rstmid_outputs: got %h want %h", act, 125'd3); end
        tick();
        reset = 0;
        a = {$urandom, $urandom}; EvictValid = 1; EvictAdr = a; EvictLine = rndLine();
        tick();
        EvictValid = 0;
        tick();
        #1;
        checks++;
        if ({BusReq, BusAdr} !== {1'b1, a[PA-1:6], 6'b0}) begin
            errors++; $display("FAIL rstmid_restart: got %b %h want 1 %h", BusReq, BusAdr, {a[PA-1:6], 6'b0});
        end
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (act !== expVec()) begin errors++; $display("FAIL rstmid_drain_c%0d: got %h want %h", c, act, expVec()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_probe();
        test_simultaneous();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cachewbbuf.md
# cachewbbuf

Two-entry victim writeback buffer between the cache and the bus interface. When replacement selects a dirty victim line, the cache hands the whole line and its address to this block in one cycle. The block queues up to two lines and drains each to the bus as a burst of beats. It also exposes a line-address probe so the cache can stall a refill that targets a line still waiting to be written back.

## Interface
Parameters:
- LINELEN, 512: cache line width in bits.
- BEATLEN, 64: bus beat width in bits; LINELEN must be an integer multiple of BEATLEN.
- PA_BITS, 56: physical address width.
- OFFSETLEN, 6: line offset bits; equals log2(LINELEN/8).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- EvictValid  in  1  cache offers a dirty victim line.
- EvictReady  out  1  buffer can accept a line this cycle.
- EvictAdr  in  PA_BITS  victim line address; offset bits are ignored.
- EvictLine  in  LINELEN  victim line data.
- BusReq  out  1  beat presented on BusAdr/BusData.
- BusAdr  out  PA_BITS  byte address of the current beat.
- BusData  out  BEATLEN  current beat data.
- BusLast  out  1  current beat is the last beat of the line.
- BusAck  in  1  bus accepted the current beat.
- ProbeAdr  in  PA_BITS  address to check against buffered lines.
- ProbeHit  out  1  ProbeAdr line matches a valid entry.
- Empty  out  1  no valid entries.

## Operation
- Storage:
  - Two entries, each holding valid, line address (PA_BITS-OFFSETLEN bits) and line data.
  - Write pointer, read pointer and a 2-bit count; both pointers wrap 1→0.
- Enqueue:
  - Occurs on EvictValid & EvictReady.
  - EvictReady = (count < 2), combinational from registered count only.
  - There is no bypass: a dequeue in the same cycle does not raise EvictReady.
- FSM states:
  - IDLE: BusReq=0. Go to BURST when count ≠ 0.
  - BURST: BusReq=1. The entry at the read pointer is presented at beat index `beat`.
    - On BusAck with beat < NBEATS-1: beat increments.
    - On BusAck with beat = NBEATS-1: the entry is freed, the read pointer advances and beat resets to 0.
      - Stay in BURST if another entry remains valid, counting an entry enqueued in this same cycle.
      - Otherwise go to IDLE.
- Beat formatting, with NBEATS = LINELEN/BEATLEN:
  - BusData = line[beat*BEATLEN +: BEATLEN], so beat 0 is the low bits.
  - BusAdr = {lineadr, OFFSETLEN'b0} + beat*(BEATLEN/8).
  - BusLast = (beat == NBEATS-1).
- Request hold: BusReq, BusAdr and BusData stay stable while BusReq is asserted and BusAck is low.
- ProbeHit:
  - Combinational compare of ProbeAdr[PA_BITS-1:OFFSETLEN] against every valid entry.
  - The entry being drained counts as valid through the cycle of its final BusAck.
  - A line being enqueued this cycle is not matched.
- Simultaneous enqueue and final-beat dequeue: both take effect and count is unchanged.
- Reset:
  - Asynchronous and immediate, including mid-burst. The partial burst is abandoned and nothing is replayed.
  - All valid bits, the pointers, count and beat go to 0; the FSM goes to IDLE.
  - Output values during reset: BusReq=0, BusLast=0, BusAdr=0, BusData=0, ProbeHit=0, Empty=1, EvictReady=1.
  - Beat outputs are zeroed when BusReq=0, so the values above hold.

## Timing
- Enqueue at edge N gives BusReq=1 with beat 0 in cycle N+1, a one-cycle latency.
- A line with NBEATS back-to-back acks completes in NBEATS cycles. The next queued line's beat 0 appears in the cycle after the last ack, with no idle bubble.
- Empty and EvictReady update on the edge after enqueue or dequeue.
- ProbeHit has zero cycles of latency from ProbeAdr.

## Structure
- The state enum `wbstatetype` (IDLE, BURST) belongs in the shared cache package.
- The same package holds the localparam NBEATS and the beat-index width, $clog2(NBEATS).
- One natural sub-module is `cachewbbeatsel`: a combinational beat mux plus address incrementer, given line data, line address and beat index.
- Registers use the codebase's asynchronous-reset flop primitives.

## Test plan
- **Single line:** enqueue adr 0x8000_0040, line = beat k holds 0x1111_1111_1111_1111*k, BusAck held high.
  - BusAdr goes 0x8000_0040, 0x8000_0048 … 0x8000_0078 with matching data.
  - BusLast is asserted on the 8th beat.
  - Empty=1 on the next cycle.
- **Ack stalls:** toggle BusAck 0/1 randomly. Beat outputs hold stable while BusAck=0, and exactly 8 beats are accepted.
- **Fill and back-to-back:**
  - Enqueue two lines in consecutive cycles, then offer a third. EvictReady=0 after the second enqueue and the third line is not accepted.
  - The second line's beat 0 follows the first line's last ack directly.
- **Probe:**
  - With 0x8000_0040 queued, ProbeAdr=0x8000_007C gives ProbeHit=1.
  - ProbeAdr=0x8000_0080 gives ProbeHit=0.
  - ProbeHit=1 in the cycle of the final ack and 0 on the next cycle.
- **Simultaneous:** with count=2, the final ack frees one entry; enqueue on the next cycle. Count ends at 2 and order is preserved.
- **Reset mid-burst:** assert reset after beat 3 is acked. BusReq=0 immediately, Empty=1 and EvictReady=1. A later enqueue starts again at beat 0.
